// File: rtl/video_timing_stream_out.sv
// video_timing_stream_out: VGA raster generator that sinks a ready/valid pixel
// stream with a start-of-frame marker and drives the DE1-SoC video DAC.
// Video stays blanked until PLL lock has been stable for LOCK_WAIT cycles, then
// frames are aligned so that a start-of-frame beat always lands on pixel (0,0).
module video_timing_stream_out #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int DATA_W    = 24,
    parameter int LOCK_WAIT = 1024,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pll_locked,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_sop,
    output logic              in_ready,
    output logic [DATA_W-1:0] vga_data,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_blank_n,
    output logic              vga_sync_n,
    output logic              running,
    output logic              underflow
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);
    localparam int LW = (LOCK_WAIT > 2) ? $clog2(LOCK_WAIT) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEGIN = HW'(H_ACTIVE + H_FRONT);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEGIN = VW'(V_ACTIVE + V_FRONT);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [LW-1:0] LOCK_END = LW'(LOCK_WAIT - 1);

    typedef enum logic [1:0] {WAIT_LOCK, SETTLE, SYNC_SOF, RUN} state_t;

    state_t          state, next_state;
    logic            lock_meta, lock_sync;
    logic [LW-1:0]   lock_cnt;
    logic [HW-1:0]   h_cnt;
    logic [VW-1:0]   v_cnt;
    logic            frame_bad;

    logic active, hs_on, vs_on, frame_end, origin, misplaced_sop, timing_live;

    assign active        = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_on         = (h_cnt >= HS_BEGIN) && (h_cnt < HS_END);
    assign vs_on         = (v_cnt >= VS_BEGIN) && (v_cnt < VS_END);
    assign frame_end     = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    assign origin        = (h_cnt == '0) && (v_cnt == '0);
    // A start-of-frame beat anywhere but (0,0) belongs to the next frame.
    assign misplaced_sop = in_valid && in_sop && !origin;
    // Raster only runs while lock holds; a lock drop idles everything next cycle.
    assign timing_live   = lock_sync && ((state == SYNC_SOF) || (state == RUN));
    // No sync-on-green.
    assign vga_sync_n    = 1'b0;

    // Two-flop synchronizer for the asynchronous PLL lock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_sync <= lock_meta;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= WAIT_LOCK;
        else     state <= next_state;
    end

    // Next-state logic; lock loss overrides every other transition.
    always_comb begin
        next_state = state;
        case (state)
            WAIT_LOCK: if (lock_sync) next_state = SETTLE;
            SETTLE: begin
                if (!lock_sync)                next_state = WAIT_LOCK;
                else if (lock_cnt == LOCK_END) next_state = SYNC_SOF;
            end
            SYNC_SOF: begin
                if (!lock_sync)                            next_state = WAIT_LOCK;
                else if (in_valid && in_sop && frame_end)  next_state = RUN;
            end
            RUN: begin
                if (!lock_sync)                 next_state = WAIT_LOCK;
                else if (frame_end && frame_bad) next_state = SYNC_SOF;
            end
            default: next_state = WAIT_LOCK;
        endcase
    end

    // Output/handshake decode from the current state.
    always_comb begin
        in_ready = 1'b0;
        running  = (state == RUN);
        case (state)
            SYNC_SOF: in_ready = lock_sync && !(in_valid && in_sop);
            RUN:      in_ready = lock_sync && active && !misplaced_sop;
            default:  in_ready = 1'b0;
        endcase
    end

    // Lock-stability counter: counts consecutive locked cycles in SETTLE only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                                   lock_cnt <= '0;
        else if (state == SETTLE && lock_sync && lock_cnt != LOCK_END) lock_cnt <= lock_cnt + LW'(1);
        else                                                       lock_cnt <= '0;
    end

    // Raster counters; held at zero whenever the raster is not live.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!timing_live) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    // Frame health: any starved pixel or early start-of-frame spoils the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_bad <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (state != RUN || frame_end)
                frame_bad <= 1'b0;
            else if (lock_sync && active && (!in_valid || misplaced_sop))
                frame_bad <= 1'b1;
            if (state == RUN && lock_sync && active && !in_valid)
                underflow <= 1'b1;
        end
    end

    // Registered DAC outputs, one cycle behind the counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_data    <= '0;
            vga_blank_n <= 1'b0;
            vga_hs      <= ~HS_POL;
            vga_vs      <= ~VS_POL;
        end else if (timing_live) begin
            vga_hs      <= hs_on ? HS_POL : ~HS_POL;
            vga_vs      <= vs_on ? VS_POL : ~VS_POL;
            // Video is shown only in RUN; alignment frames stay blanked.
            vga_blank_n <= (state == RUN) && active;
            vga_data    <= (state == RUN && active && in_valid && !misplaced_sop) ? in_data : '0;
        end else begin
            vga_data    <= '0;
            vga_blank_n <= 1'b0;
            vga_hs      <= ~HS_POL;
            vga_vs      <= ~VS_POL;
        end
    end
endmodule
